// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared constants for the scoreboarded register file
package regfile_sb_pkg;

   localparam int XLEN_DEF = 64;
   localparam int NREG_DEF = 32;

   localparam int RD_LSB  = 7;
   localparam int RD_MSB  = 11;
   localparam int RS1_LSB = 15;
   localparam int RS1_MSB = 19;
   localparam int RS2_LSB = 20;
   localparam int RS2_MSB = 24;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// rtl/regfile_sb_scoreboard.sv - pending-write flags, pending count, hazard detect and wb error pulse
module regfile_sb_scoreboard
   import regfile_sb_pkg::*;
#(
   parameter int NREG    = NREG_DEF,
   parameter int ZERO_R0 = 1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          issue_valid,
   input  logic          issue_wr,
   input  logic [AW-1:0] rs1,
   input  logic [AW-1:0] rs2,
   input  logic [AW-1:0] rd,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_addr,
   output logic          hazard,
   output logic [NREG-1:0] busy_vec,
   output logic [AW:0]   pend_cnt,
   output logic          wb_err
);

   localparam bit ZR = (ZERO_R0 != 0);

   logic byp1, byp2, byp_rd, haz_raw, rd_ok, set_en, clr_en, inc, dec;
   logic [NREG-1:0] busy_nxt;

   assign byp1    = wb_valid && (wb_addr == rs1);
   assign byp2    = wb_valid && (wb_addr == rs2);
   assign byp_rd  = wb_valid && (wb_addr == rd);
   assign haz_raw = issue_valid &&
                    ((busy_vec[rs1] && !byp1) ||
                     (busy_vec[rs2] && !byp2) ||
                     (issue_wr && busy_vec[rd] && !byp_rd));
   assign hazard  = haz_raw && !rst;

   assign rd_ok  = !(ZR && (rd == '0));
   assign set_en = issue_valid && !haz_raw && issue_wr && rd_ok;
   assign clr_en = wb_valid && busy_vec[wb_addr];

   // A set onto a flag that is being cleared leaves the flag (and count) unchanged.
   assign inc = set_en && !busy_vec[rd];
   assign dec = clr_en && !(set_en && (rd == wb_addr));

   always_comb begin
      busy_nxt = busy_vec;
      if (clr_en) busy_nxt[wb_addr] = 1'b0;
      if (set_en) busy_nxt[rd] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_vec <= '0;
         pend_cnt <= '0;
         wb_err   <= 1'b0;
      end else begin
         busy_vec <= busy_nxt;
         wb_err   <= wb_valid && !busy_vec[wb_addr];
         if (inc && !dec)
            pend_cnt <= pend_cnt + {{AW{1'b0}}, 1'b1};
         else if (dec && !inc)
            pend_cnt <= pend_cnt - {{AW{1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write bypass and a pending-write scoreboard
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int NREG    = NREG_DEF,
   parameter int ZERO_R0 = 1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instr,
   input  logic            issue_valid,
   input  logic            issue_wr,
   output logic [XLEN-1:0] read_data_1,
   output logic [XLEN-1:0] read_data_2,
   output logic            hazard,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic [NREG-1:0] busy_vec,
   output logic [AW:0]     pend_cnt,
   output logic            wb_err
);

   localparam bit ZR = (ZERO_R0 != 0);

   logic [AW-1:0]   rs1, rs2, rd;
   logic            wr_en;
   logic            unused_instr;
   logic [XLEN-1:0] regs [NREG];

   assign rs1 = AW'(instr[RS1_MSB:RS1_LSB]);
   assign rs2 = AW'(instr[RS2_MSB:RS2_LSB]);
   assign rd  = AW'(instr[RD_MSB:RD_LSB]);
   assign unused_instr = ^{instr[31:25], instr[14:12], instr[6:0]};

   assign wr_en = wb_valid && !(ZR && (wb_addr == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Writeback data forwards to a same-cycle read; hardwired r0 overrides it.
   always_comb begin
      read_data_1 = regs[rs1];
      read_data_2 = regs[rs2];
      if (wb_valid && (wb_addr == rs1)) read_data_1 = wb_data;
      if (wb_valid && (wb_addr == rs2)) read_data_2 = wb_data;
      if (ZR && (rs1 == '0)) read_data_1 = '0;
      if (ZR && (rs2 == '0)) read_data_2 = '0;
      if (rst) begin
         read_data_1 = '0;
         read_data_2 = '0;
      end
   end

   regfile_sb_scoreboard #(
      .NREG    (NREG),
      .ZERO_R0 (ZERO_R0)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_wr    (issue_wr),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd          (rd),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .hazard      (hazard),
      .busy_vec    (busy_vec),
      .pend_cnt    (pend_cnt),
      .wb_err      (wb_err)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - table-driven self-checking bench for regfile_sb
module tb_regfile_sb;

   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int NV   = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [31:0]     instr;
   logic            issue_valid, issue_wr, wb_valid;
   logic [XLEN-1:0] read_data_1, read_data_2, wb_data;
   logic            hazard, wb_err;
   logic [AW-1:0]   wb_addr;
   logic [NREG-1:0] busy_vec;
   logic [AW:0]     pend_cnt;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .ZERO_R0(1)) dut (
      .clk(clk), .rst(rst), .instr(instr), .issue_valid(issue_valid), .issue_wr(issue_wr),
      .read_data_1(read_data_1), .read_data_2(read_data_2), .hazard(hazard),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .busy_vec(busy_vec), .pend_cnt(pend_cnt), .wb_err(wb_err)
   );

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic        iv, iw, wv;
      logic [4:0]  wa;
      logic [63:0] wd;
      logic [63:0] e_rd1, e_rd2;
      logic        e_haz;
      logic [31:0] e_busy;
      logic [5:0]  e_cnt;
      logic        e_err;
   } vec_t;

   typedef struct {
      logic [31:0] busy;
      logic [5:0]  cnt;
      logic        err;
      string       tag;
   } post_t;

   vec_t  vecs [NV];
   post_t exp_q [$];
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Opcode/funct bits are filled with junk to show they are ignored.
   function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      return {7'h5a, rs2, rs1, 3'b101, rd, 7'h33};
   endfunction

   function automatic vec_t mkv(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic iv, input logic iw, input logic wv, input logic [4:0] wa,
                                input logic [63:0] wd, input logic [63:0] e1, input logic [63:0] e2,
                                input logic eh, input logic [31:0] eb, input logic [5:0] ec, input logic ee);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.iv = iv; v.iw = iw; v.wv = wv; v.wa = wa; v.wd = wd;
      v.e_rd1 = e1; v.e_rd2 = e2; v.e_haz = eh; v.e_busy = eb; v.e_cnt = ec; v.e_err = ee;
      return v;
   endfunction

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic iv, input logic iw, input logic wv, input logic [4:0] wa,
                        input logic [63:0] wd);
      instr = mk_instr(rs1, rs2, rd);
      issue_valid = iv; issue_wr = iw; wb_valid = wv; wb_addr = wa; wb_data = wd;
   endtask

   task automatic check_post();
      post_t p;
      if (exp_q.size() == 0) begin
         chk("queue_empty", 64'd1, 64'd0);
      end else begin
         p = exp_q.pop_front();
         chk({p.tag, "_busy"}, 64'(busy_vec), 64'(p.busy));
         chk({p.tag, "_cnt"},  64'(pend_cnt), 64'(p.cnt));
         chk({p.tag, "_err"},  64'(wb_err),   64'(p.err));
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      //             rs1 rs2 rd  iv iw wv wa  wd            rd1           rd2           hz busy         cnt err
      vecs[0]  = mkv(5,  0,  0,  0, 0, 0, 0,  64'h0,        64'h0,        64'h0,        0, 32'h0,       0, 0);
      vecs[1]  = mkv(3,  0,  0,  0, 0, 1, 3,  64'hDEAD,     64'hDEAD,     64'h0,        0, 32'h0,       0, 1);
      vecs[2]  = mkv(3,  3,  20, 0, 1, 0, 0,  64'h0,        64'hDEAD,     64'hDEAD,     0, 32'h0,       0, 0);
      vecs[3]  = mkv(3,  0,  7,  1, 1, 0, 0,  64'h0,        64'hDEAD,     64'h0,        0, 32'h80,      1, 0);
      vecs[4]  = mkv(0,  7,  0,  1, 0, 0, 0,  64'h0,        64'h0,        64'h0,        1, 32'h80,      1, 0);
      vecs[5]  = mkv(0,  7,  0,  1, 0, 1, 7,  64'h55,       64'h0,        64'h55,       0, 32'h0,       0, 0);
      vecs[6]  = mkv(7,  3,  4,  1, 1, 0, 0,  64'h0,        64'h55,       64'hDEAD,     0, 32'h10,      1, 0);
      vecs[7]  = mkv(0,  0,  9,  1, 1, 0, 0,  64'h0,        64'h0,        64'h0,        0, 32'h210,     2, 0);
      vecs[8]  = mkv(0,  0,  4,  1, 1, 1, 4,  64'h44,       64'h0,        64'h0,        0, 32'h210,     2, 0);
      vecs[9]  = mkv(4,  9,  4,  1, 1, 0, 0,  64'h0,        64'h44,       64'h0,        1, 32'h210,     2, 0);
      vecs[10] = mkv(9,  0,  0,  1, 0, 1, 9,  64'h99,       64'h99,       64'h0,        0, 32'h10,      1, 0);
      vecs[11] = mkv(0,  0,  0,  1, 1, 1, 0,  64'hFFFF,     64'h0,        64'h0,        0, 32'h10,      1, 1);
      vecs[12] = mkv(0,  4,  0,  0, 0, 0, 0,  64'h0,        64'h0,        64'h44,       0, 32'h10,      1, 0);
      vecs[13] = mkv(4,  12, 12, 1, 1, 1, 4,  64'h4444,     64'h4444,     64'h0,        0, 32'h1000,    1, 0);
      vecs[14] = mkv(0,  0,  13, 1, 1, 0, 0,  64'h0,        64'h0,        64'h0,        0, 32'h3000,    2, 0);
      vecs[15] = mkv(0,  0,  14, 1, 1, 0, 0,  64'h0,        64'h0,        64'h0,        0, 32'h7000,    3, 0);

      rst = 1'b1;
      drive(5, 0, 0, 0, 0, 0, 0, 64'h0);
      #12;
      chk("in_reset_rd1", read_data_1, 64'h0);
      chk("in_reset_cnt", 64'(pend_cnt), 64'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         post_t p;
         @(negedge clk);
         drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].iv, vecs[i].iw,
               vecs[i].wv, vecs[i].wa, vecs[i].wd);
         #1;
         chk($sformatf("v%0d_rd1", i), read_data_1, vecs[i].e_rd1);
         chk($sformatf("v%0d_rd2", i), read_data_2, vecs[i].e_rd2);
         chk($sformatf("v%0d_haz", i), 64'(hazard), 64'(vecs[i].e_haz));
         p.busy = vecs[i].e_busy; p.cnt = vecs[i].e_cnt; p.err = vecs[i].e_err;
         p.tag = $sformatf("v%0d", i);
         exp_q.push_back(p);
         @(posedge clk);
         #1;
         check_post();
      end

      // Asynchronous reset between edges with three writes pending and live traffic on the inputs.
      #2;
      drive(12, 3, 13, 1, 1, 1, 12, 64'hABCD);
      rst = 1'b1;
      #1;
      chk("arst_busy", 64'(busy_vec), 64'h0);
      chk("arst_cnt",  64'(pend_cnt), 64'h0);
      chk("arst_rd1",  read_data_1, 64'h0);
      chk("arst_rd2",  read_data_2, 64'h0);
      chk("arst_haz",  64'(hazard), 64'h0);
      @(posedge clk);
      #1;
      chk("arst_edge_busy", 64'(busy_vec), 64'h0);

      // First cycles after release behave as from empty; storage was cleared too.
      @(negedge clk);
      rst = 1'b0;
      drive(3, 12, 5, 1, 1, 0, 0, 64'h0);
      #1;
      chk("post_rst_rd1", read_data_1, 64'h0);
      chk("post_rst_haz", 64'(hazard), 64'h0);
      begin
         post_t p;
         p.busy = 32'h20; p.cnt = 1; p.err = 0; p.tag = "post_rst";
         exp_q.push_back(p);
      end
      @(posedge clk);
      #1;
      check_post();

      @(negedge clk);
      drive(0, 0, 31, 1, 1, 0, 0, 64'h0);
      begin
         post_t p;
         p.busy = 32'h8000_0020; p.cnt = 2; p.err = 0; p.tag = "rd31";
         exp_q.push_back(p);
      end
      @(posedge clk);
      #1;
      check_post();

      @(negedge clk);
      drive(31, 0, 0, 1, 0, 0, 0, 64'h0);
      #1;
      chk("rs1_31_haz", 64'(hazard), 64'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
